btn_conditioner: RTL

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 129 ++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// Five-channel pushbutton conditioner: 2-FF synchronizer, debouncer,
// press/release pulses and per-channel auto-repeat.
module btn_conditioner #(
    parameter int DB_CYCLES     = 1000000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_pulse,
    output logic [4:0] btn_release,
    output logic       any_pressed
);

    localparam int CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RELEASED,
        HOLD_DELAY,
        HOLD_REPEAT
    } state_t;

    logic [4:0] sync1;
    logic [4:0] sync2;

    // Bring the asynchronous buttons into the clock domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic [RW-1:0] rcnt;
        state_t        state;
        logic          lvl;
        logic          pls;
        logic          rel;
        logic          done;

        // A level change is accepted on the last cycle of a stable run.
        assign done = (sync2[i] != lvl) && (cnt == DB_LAST);

        // Debounce counter, accepted level and press/repeat/release FSM.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt   <= '0;
                rcnt  <= '0;
                state <= RELEASED;
                lvl   <= 1'b0;
                pls   <= 1'b0;
                rel   <= 1'b0;
            end else begin
                pls <= 1'b0;
                rel <= 1'b0;

                if (sync2[i] == lvl) begin
                    cnt <= '0;
                end else if (cnt == DB_LAST) begin
                    cnt <= '0;
                    lvl <= sync2[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end

                if (done && !sync2[i]) begin
                    state <= RELEASED;
                    rcnt  <= '0;
                    rel   <= 1'b1;
                end else begin
                    unique case (state)
                        RELEASED: begin
                            if (done && sync2[i]) begin
                                state <= HOLD_DELAY;
                                rcnt  <= '0;
                                pls   <= 1'b1;
                            end
                        end
                        HOLD_DELAY: begin
                            if (REPEAT_EN != 0) begin
                                if (rcnt == RD_LAST) begin
                                    rcnt  <= '0;
                                    pls   <= 1'b1;
                                    state <= HOLD_REPEAT;
                                end else begin
                                    rcnt <= rcnt + 1'b1;
                                end
                            end
                        end
                        HOLD_REPEAT: begin
                            if (rcnt == RP_LAST) begin
                                rcnt <= '0;
                                pls  <= 1'b1;
                            end else begin
                                rcnt <= rcnt + 1'b1;
                            end
                        end
                        default: begin
                            state <= RELEASED;
                            rcnt  <= '0;
                        end
                    endcase
                end
            end
        end

        assign btn_level[i]   = lvl;
        assign btn_pulse[i]   = pls;
        assign btn_release[i] = rel;
    end

    assign any_pressed = |btn_level;

endmodule
